// File: rtl/fifo_rd_stream.sv
// Read-domain consumer for the async FIFO: pops words and presents them as a
// registered valid/ready stream through a 2-entry skid buffer, counting deliveries.
//
// state | meaning
// EMPTY | no word held, m_valid=0
// ONE   | head word on m_data, skid register unused
// FULL  | head word on m_data plus one word waiting in the skid register
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             enable,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNTW-1:0]  rd_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             occ;
    logic [DSIZE-1:0] skid;
    logic             push;
    logic             pop;

    // Pop decision uses only registered occupancy, keeping m_ready off this path.
    assign fifo_rinc = !rrst && enable && !fifo_rempty && (occ != FULL);
    assign push      = fifo_rinc;
    assign pop       = m_valid && m_ready;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            occ      <= EMPTY;
            m_valid  <= 1'b0;
            m_data   <= '0;
            skid     <= '0;
            rd_count <= '0;
        end else begin
            if (pop) begin
                rd_count <= rd_count + CNTW'(1);
            end
            unique case (occ)
                EMPTY: begin
                    if (push) begin
                        m_data  <= fifo_rdata;
                        m_valid <= 1'b1;
                        occ     <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        skid <= fifo_rdata;
                        occ  <= FULL;
                    end else if (pop && !push) begin
                        m_valid <= 1'b0;
                        occ     <= EMPTY;
                    end else if (push && pop) begin
                        m_data <= fifo_rdata;
                    end
                end
                FULL: begin
                    if (pop) begin
                        m_data <= skid;
                        occ    <= ONE;
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    occ     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a behavioural FIFO feeds the main instance,
// a second CNTW=4 instance with an always-full source exercises counter wrap.
module tb_fifo_rd_stream;

    logic        rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic        rrst, enable, m_ready;
    logic [7:0]  fifo_rdata;
    logic        fifo_rempty, fifo_rinc;
    logic [7:0]  m_data;
    logic        m_valid;
    logic [15:0] rd_count;

    logic        r4, en4, rdy4, e4, rinc4, mv4;
    logic [7:0]  d4, md4;
    logic [3:0]  cnt4;

    logic [7:0]  mem [128];
    logic [6:0]  rptr = '0;
    logic [6:0]  wptr = '0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          bad_pop = 0;
    int          bad_occ = 0;
    int          occ_m = 0;
    int          xfer4 = 0;
    logic [7:0]  got [$];

    assign fifo_rdata  = mem[rptr];
    assign fifo_rempty = (rptr == wptr);

    fifo_rd_stream #(.DSIZE(8), .CNTW(16)) dut (
        .rclk(rclk), .rrst(rrst), .enable(enable),
        .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rinc(fifo_rinc),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .rd_count(rd_count)
    );

    fifo_rd_stream #(.DSIZE(8), .CNTW(4)) dut4 (
        .rclk(rclk), .rrst(r4), .enable(en4),
        .fifo_rdata(d4), .fifo_rempty(e4), .fifo_rinc(rinc4),
        .m_data(md4), .m_valid(mv4), .m_ready(rdy4), .rd_count(cnt4)
    );

    // FIFO read pointer, transfer log and occupancy reference model
    always @(posedge rclk) begin
        if (fifo_rinc) rptr <= rptr + 7'd1;
        if (fifo_rinc && fifo_rempty) bad_pop++;
        if (fifo_rinc && occ_m == 2) bad_occ++;
        if (!rrst && m_valid && m_ready) got.push_back(m_data);
        if (rrst) occ_m <= 0;
        else occ_m <= occ_m + (fifo_rinc ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
        if (!r4 && mv4 && rdy4) xfer4++;
    end

    task automatic load_words();
        for (int k = 1; k <= 8; k++) begin
            mem[wptr] = 8'(5 * k);
            wptr = wptr + 7'd1;
        end
    endtask

    task automatic test_reset();
        rrst = 1'b1; enable = 1'b1; m_ready = 1'b1;
        load_words();
        for (int i = 0; i < 2; i++) begin
            @(negedge rclk); #1;
            n_cmp++;
            if (fifo_rinc !== 1'b0) begin n_bad++; $display("FAIL reset_rinc: got %b expected 0", fifo_rinc); end
        end
        n_cmp++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_cmp++;
        if (m_data !== 8'd0) begin n_bad++; $display("FAIL reset_m_data: got %0d expected 0", m_data); end
        n_cmp++;
        if (rd_count !== 16'd0) begin n_bad++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count); end
        n_cmp++;
        if (rptr !== 7'd0) begin n_bad++; $display("FAIL reset_no_pop: rptr %0d expected 0", rptr); end
        enable = 1'b0;
        rrst   = 1'b0;
    endtask

    task automatic test_streaming();
        int rinc_cnt;
        got.delete();
        @(negedge rclk);
        enable = 1'b1; m_ready = 1'b1;
        #1 rinc_cnt = int'(fifo_rinc);
        for (int k = 1; k <= 10; k++) begin
            @(negedge rclk); #1;
            rinc_cnt += int'(fifo_rinc);
            n_cmp++;
            if (k <= 8) begin
                if ({m_valid, m_data} !== {1'b1, 8'(5 * k)}) begin
                    n_bad++; $display("FAIL stream_data[%0d]: got v=%b d=%0d expected v=1 d=%0d", k, m_valid, m_data, 5 * k);
                end
            end else if (m_valid !== 1'b0) begin
                n_bad++; $display("FAIL stream_idle[%0d]: got v=%b expected 0", k, m_valid);
            end
        end
        n_cmp++;
        if (rinc_cnt != 8) begin n_bad++; $display("FAIL stream_pops: got %0d expected 8", rinc_cnt); end
        n_cmp++;
        if (rd_count !== 16'd8) begin n_bad++; $display("FAIL stream_rd_count: got %0d expected 8", rd_count); end
        n_cmp++;
        if (got.size() != 8) begin n_bad++; $display("FAIL stream_count: got %0d words expected 8", got.size()); end
        else for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got[i] !== 8'(5 * (i + 1))) begin n_bad++; $display("FAIL stream_order[%0d]: got %0d expected %0d", i, got[i], 5 * (i + 1)); end
        end
        n_cmp++;
        if (bad_pop != 0) begin n_bad++; $display("FAIL stream_underflow: got %0d pops while empty expected 0", bad_pop); end
    endtask

    task automatic test_backpressure();
        int pops;
        @(negedge rclk);
        m_ready = 1'b0;
        got.delete();
        load_words();
        #1 pops = int'(fifo_rinc);
        for (int k = 1; k <= 5; k++) begin
            @(negedge rclk); #1;
            pops += int'(fifo_rinc);
            n_cmp++;
            if ({m_valid, m_data} !== {1'b1, 8'd5}) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d expected v=1 d=5", k, m_valid, m_data);
            end
        end
        n_cmp++;
        if (pops != 2) begin n_bad++; $display("FAIL bp_pops: got %0d expected 2", pops); end
        m_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge rclk); #1;
            n_cmp++;
            if (j <= 7) begin
                if ({m_valid, m_data} !== {1'b1, 8'(5 * (j + 1))}) begin
                    n_bad++; $display("FAIL bp_drain[%0d]: got v=%b d=%0d expected v=1 d=%0d", j, m_valid, m_data, 5 * (j + 1));
                end
            end else if (m_valid !== 1'b0) begin
                n_bad++; $display("FAIL bp_drain_idle: got v=%b expected 0", m_valid);
            end
        end
        n_cmp++;
        if (got.size() != 8) begin n_bad++; $display("FAIL bp_count: got %0d words expected 8", got.size()); end
        else for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got[i] !== 8'(5 * (i + 1))) begin n_bad++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i, got[i], 5 * (i + 1)); end
        end
    endtask

    task automatic test_alternating();
        @(negedge rclk);
        got.delete();
        load_words();
        for (int i = 0; i < 30; i++) begin
            m_ready = (i % 2 == 0);
            @(negedge rclk);
        end
        m_ready = 1'b1;
        repeat (4) @(negedge rclk);
        n_cmp++;
        if (got.size() != 8) begin n_bad++; $display("FAIL alt_count: got %0d words expected 8", got.size()); end
        else for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got[i] !== 8'(5 * (i + 1))) begin n_bad++; $display("FAIL alt_order[%0d]: got %0d expected %0d", i, got[i], 5 * (i + 1)); end
        end
        n_cmp++;
        if (bad_occ != 0) begin n_bad++; $display("FAIL alt_pop_when_full: got %0d expected 0", bad_occ); end
    endtask

    task automatic test_enable_drop();
        logic [6:0] base;
        @(negedge rclk);
        got.delete();
        m_ready = 1'b0; enable = 1'b1;
        base = rptr;
        load_words();
        repeat (2) @(negedge rclk);
        #1;
        n_cmp++;
        if ({m_valid, m_data, fifo_rinc} !== {1'b1, 8'd5, 1'b0}) begin
            n_bad++; $display("FAIL en_full: got v=%b d=%0d rinc=%b expected v=1 d=5 rinc=0", m_valid, m_data, fifo_rinc);
        end
        n_cmp++;
        if (rptr !== 7'(base + 7'd2)) begin n_bad++; $display("FAIL en_full_pops: rptr %0d expected %0d", rptr, base + 2); end
        enable = 1'b0; m_ready = 1'b1;
        @(negedge rclk); #1;
        n_cmp++;
        if ({m_valid, m_data, fifo_rinc} !== {1'b1, 8'd10, 1'b0}) begin
            n_bad++; $display("FAIL en_drain2: got v=%b d=%0d rinc=%b expected v=1 d=10 rinc=0", m_valid, m_data, fifo_rinc);
        end
        repeat (2) begin
            @(negedge rclk); #1;
            n_cmp++;
            if ({m_valid, fifo_rinc} !== 2'b00) begin
                n_bad++; $display("FAIL en_idle: got v=%b rinc=%b expected v=0 rinc=0", m_valid, fifo_rinc);
            end
        end
        n_cmp++;
        if (rptr !== 7'(base + 7'd2)) begin n_bad++; $display("FAIL en_no_pop: rptr %0d expected %0d", rptr, base + 2); end
        enable = 1'b1;
        #1;
        n_cmp++;
        if (fifo_rinc !== 1'b1) begin n_bad++; $display("FAIL en_resume_rinc: got %b expected 1", fifo_rinc); end
        @(negedge rclk); #1;
        n_cmp++;
        if ({m_valid, m_data} !== {1'b1, 8'd15}) begin
            n_bad++; $display("FAIL en_resume: got v=%b d=%0d expected v=1 d=15", m_valid, m_data);
        end
        repeat (10) @(negedge rclk);
        n_cmp++;
        if (got.size() != 8) begin n_bad++; $display("FAIL en_count: got %0d words expected 8", got.size()); end
        else for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got[i] !== 8'(5 * (i + 1))) begin n_bad++; $display("FAIL en_order[%0d]: got %0d expected %0d", i, got[i], 5 * (i + 1)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] base;
        @(negedge rclk);
        got.delete();
        m_ready = 1'b0; enable = 1'b1;
        base = rptr;
        load_words();
        repeat (2) @(negedge rclk);
        rrst = 1'b1;
        #1;
        n_cmp++;
        if (fifo_rinc !== 1'b0) begin n_bad++; $display("FAIL rm_rinc_full: got %b expected 0", fifo_rinc); end
        @(negedge rclk); #1;
        n_cmp++;
        if ({m_valid, fifo_rinc} !== 2'b00) begin
            n_bad++; $display("FAIL rm_after_reset: got v=%b rinc=%b expected v=0 rinc=0", m_valid, fifo_rinc);
        end
        n_cmp++;
        if (rd_count !== 16'd0) begin n_bad++; $display("FAIL rm_rd_count: got %0d expected 0", rd_count); end
        @(negedge rclk);
        n_cmp++;
        if (rptr !== 7'(base + 7'd2)) begin n_bad++; $display("FAIL rm_no_pop: rptr %0d expected %0d", rptr, base + 2); end
        rrst = 1'b0; m_ready = 1'b1;
        #1;
        n_cmp++;
        if (fifo_rinc !== 1'b1) begin n_bad++; $display("FAIL rm_resume_rinc: got %b expected 1", fifo_rinc); end
        @(negedge rclk); #1;
        n_cmp++;
        if ({m_valid, m_data} !== {1'b1, 8'd15}) begin
            n_bad++; $display("FAIL rm_first: got v=%b d=%0d expected v=1 d=15", m_valid, m_data);
        end
        repeat (10) @(negedge rclk);
        n_cmp++;
        if (got.size() != 6) begin n_bad++; $display("FAIL rm_count: got %0d words expected 6", got.size()); end
        else for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got[i] !== 8'(5 * (i + 3))) begin n_bad++; $display("FAIL rm_order[%0d]: got %0d expected %0d", i, got[i], 5 * (i + 3)); end
        end
        n_cmp++;
        if (rd_count !== 16'd6) begin n_bad++; $display("FAIL rm_rd_count_final: got %0d expected 6", rd_count); end
    endtask

    task automatic test_wrap();
        @(negedge rclk);
        r4 = 1'b0; en4 = 1'b1;
        repeat (17) @(negedge rclk);
        en4 = 1'b0;
        repeat (5) @(negedge rclk);
        #1;
        n_cmp++;
        if (xfer4 != 17) begin n_bad++; $display("FAIL wrap_transfers: got %0d expected 17", xfer4); end
        n_cmp++;
        if (cnt4 !== 4'd1) begin n_bad++; $display("FAIL wrap_rd_count: got %0d expected 1", cnt4); end
    endtask

    initial begin
        rrst = 1'b1; enable = 1'b0; m_ready = 1'b0;
        r4 = 1'b1; en4 = 1'b0; rdy4 = 1'b1; e4 = 1'b0; d4 = 8'hA5;
        test_reset();
        test_streaming();
        test_backpressure();
        test_alternating();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the team's asynchronous FIFO (fifo1). Lives entirely in the read clock domain.
- Pops words through the FIFO's rdata/rempty/rinc interface and presents them downstream as a registered valid/ready stream.
- A 2-entry skid buffer decouples fifo_rinc from m_ready, so there is no combinational path between the two, and gives full throughput.
- Also keeps a running count of delivered words.

Parameters:
- DSIZE, 8, data word width; must match the FIFO's DSIZE.
- CNTW, 16, width of the delivered-word counter.

Ports:
- rclk  in  1  read-domain clock; everything samples on the rising edge.
- rrst  in  1  synchronous, active-high reset.
- enable  in  1  permits new pops from the FIFO; buffered words still drain when low.
- fifo_rdata  in  DSIZE  FIFO read data; valid whenever fifo_rempty=0 (combinational read of the current read address).
- fifo_rempty  in  1  FIFO empty flag.
- fifo_rinc  out  1  FIFO pop strobe, one word per cycle while high.
- m_data  out  DSIZE  downstream data (head of the skid buffer).
- m_valid  out  1  m_data holds a word.
- m_ready  in  1  downstream accepts the word.
- rd_count  out  CNTW  number of words delivered downstream.

Behaviour:
- Reset (rrst=1 at an edge):
  - occ=0, m_valid=0, m_data=0, internal skid register=0, rd_count=0.
  - fifo_rinc is forced 0 during any cycle with rrst=1.
  - Reset mid-operation discards buffered words; no pop happens in the reset cycle.
- Occupancy:
  - occ ∈ {0,1,2}, stored as states EMPTY, ONE, FULL.
  - m_valid = (occ != 0), registered.
- Pop rule:
  - fifo_rinc = !rrst && enable && !fifo_rempty && (occ != 2).
  - It depends only on registered occ, never on m_ready.
  - It is never asserted while fifo_rempty=1, so the FIFO is never underflowed.
- Capture:
  - When fifo_rinc=1, fifo_rdata is sampled at that same rclk edge.
  - The word appears on m_data/m_valid the next cycle (1-cycle latency) if the buffer was EMPTY.
  - Otherwise it goes to the skid register.
- Downstream handshake:
  - A transfer occurs at an edge where m_valid && m_ready.
  - m_data and m_valid stay stable while m_valid && !m_ready.
- Transitions (push = fifo_rinc, pop = downstream transfer):
  - EMPTY: push -> ONE (head <= fifo_rdata); no push -> EMPTY.
  - ONE:
    - push && !pop -> FULL (skid <= fifo_rdata).
    - pop && !push -> EMPTY.
    - push && pop -> ONE (head <= fifo_rdata).
    - neither -> ONE.
  - FULL (no push possible):
    - pop -> ONE (head <= skid).
    - no pop -> FULL.
- Ordering: words exit strictly in FIFO order; none are lost or duplicated.
- Throughput: with the FIFO non-empty and m_ready=1 held, one word is delivered per cycle in steady state (occ=1).
- rd_count:
  - Increments by 1 on each downstream transfer.
  - Wraps modulo 2^CNTW (all-ones + 1 -> 0).
- enable:
  - enable=0 blocks new pops only; buffered words still drain.
  - Deasserting while FULL delivers both held words, then m_valid=0.
- fifo_rempty rising in the same cycle as a pop: no pop that cycle; buffer contents are unaffected.

Test Plan:
- Reset then idle: rrst=1 for 2 cycles with the FIFO holding 5 -> fifo_rinc=0 during reset; m_valid=0, m_data=0, rd_count=0 after reset.
- Streaming: FIFO holds 5,10,...,40, enable=1, m_ready=1 -> fifo_rinc high 8 cycles; m_data sequence 5,10,...,40 on 8 consecutive cycles starting 1 cycle after the first pop; rd_count=8; fifo_rinc never high while rempty=1.
- Backpressure: same data, m_ready=0 -> exactly 2 pops, occ=FULL, m_data=5 held stable. m_ready=1 thereafter -> 5,10,15,...,40 delivered in order with no gaps after the first.
- Alternating m_ready (1,0,1,0...) with 8 words -> all 8 delivered in order, no duplicates; fifo_rinc never asserted while occ=2.
- enable drop: enable=0 while FULL holding 5,10 -> both delivered, then m_valid=0 and no further pops. enable=1 -> resumes with 15.
- Reset mid-stream: rrst=1 while occ=2 -> next cycle m_valid=0, rd_count=0, no pop in the reset cycle. After release, the next word from the FIFO is delivered first. Counter wrap check with CNTW=4: 17 transfers -> rd_count=1.
